sad_search_engine: RTL and testbench
====================================

// Module: sad_search_engine
// PURPOSE
//   Parametrised, fully pipelined SAD engine for block-matching motion estimation.
//   Holds one current block and accepts one full candidate block per cycle.
//   Emits a tagged SAD for every candidate.
//   Tracks the minimum SAD over a search delimited by first/last flags and reports the best candidate index.
//   Sits between the search-window fetch logic and the motion-vector decision stage.
// PARAMETERS
//   PIX_W  8   pixel width in bits
//   ROWS   4   block height in pixels
//   COLS   4   block width in pixels
//   IDX_W  8   candidate index/tag width
//   Derived: N = ROWS*COLS; T = clog2(N); SAD_W = PIX_W + T; L = 1 + T
// PORTS
//   clk         in   1            clock, rising edge
//   rst         in   1            synchronous reset, active high
//   cur_load    in   1            capture cur_blk into the current-block register
//   cur_blk     in   N*PIX_W      current block; pixel (r,c) at [(r*COLS+c)*PIX_W +: PIX_W]
//   in_valid    in   1            candidate beat valid; one beat accepted per cycle, never stalls
//   in_first    in   1            beat is the first candidate of a search
//   in_last     in   1            beat is the last candidate of a search
//   in_idx      in   IDX_W        candidate tag, carried to the outputs
//   cand_blk    in   N*PIX_W      candidate block, same packing as cur_blk
//   sad_valid   out  1            sad_out/sad_idx valid
//   sad_out     out  SAD_W        SAD of the candidate
//   sad_idx     out  IDX_W        tag of the candidate
//   best_valid  out  1            one-cycle pulse: search result valid
//   best_sad    out  SAD_W        minimum SAD of the completed search
//   best_idx    out  IDX_W        tag of the minimum-SAD candidate
// BEHAVIOUR
//   Reset (rst=1 at a clock edge): every output is 0; the current-block register is 0.
//     All pipeline valid bits are 0; the search-open flag is 0; the running minimum is 0.
//   Current block:
//     - cur_load is registered; it affects beats presented from the next cycle on.
//     - A beat in the same cycle as cur_load uses the old block.
//     - Beats already in flight are unaffected by cur_load.
//   Stage 1 (absolute difference):
//     - Per pixel |cand - cur| on PIX_W bits, unsigned.
//     - No wrap: compute larger minus smaller.
//   Stages 2..L (adder tree):
//     - T registered levels of pairwise adds, each level one bit wider.
//     - If N is not a power of two, pad the tree with zero leaves.
//   Pipeline sideband:
//     - valid, first, last and idx travel alongside the data.
//     - sad_valid asserts exactly L cycles after the in_valid beat (L=5 at defaults).
//     - Throughput is 1 SAD/cycle; bubbles (in_valid=0) propagate as sad_valid=0.
//   Max SAD = N*(2^PIX_W - 1), so the sum never overflows SAD_W (4080 at defaults).
//   Search tracker (runs on the output side of the pipeline, at the sad_valid beat):
//     - Beat with first=1, or any beat while no search is open:
//       run_min<=sad, run_idx<=idx, open<=1.
//     - A first=1 beat while a search is open discards the open search (restart).
//     - Otherwise, when open: update only if sad < run_min (strict).
//       On a tie the earlier candidate wins.
//     - Beat with last=1 (first=1 allowed in the same beat):
//       the next cycle gives best_valid=1, with best_sad/best_idx including that beat; then open<=0.
//     - best_valid therefore pulses L+1 cycles after the last beat's in_valid.
//     - best_sad/best_idx hold their value until the next pulse.
//     - Back-to-back searches (last then first on consecutive beats) need no idle cycle.
//   Reset mid-search: all in-flight beats are dropped and no best_valid is produced.
//     Beats presented after reset release start clean.
//   Beats with in_valid=0 ignore in_first/in_last/in_idx.
// TESTING
//   1. cur = cand = ramp 0..15 -> sad_out=0, sad_idx=in_idx, sad_valid exactly 5 cycles after in_valid.
//   2. cur all 0x00, cand all 0xFF, then swapped -> sad_out=4080 both times (|a-b| symmetric, no overflow).
//   3. Search of 4 beats with SADs 100,40,40,90, idx 3,7,9,2 (first on beat 0, last on beat 3)
//      -> one best_valid pulse at 6 cycles after beat 3, best_sad=40, best_idx=7.
//   4. Two back-to-back searches {SAD 50 idx1, last} then {SAD 20 idx4 first+last} with no gap
//      -> pulses on consecutive cycles: (50,1) then (20,4).
//   5. cur_load of a new block in the same cycle as a beat, then the same cand on the next cycle
//      -> the first SAD uses the old cur, the second uses the new.
//   6. rst asserted 2 cycles into a 4-beat search
//      -> no sad_valid/best_valid for those beats; all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/sad_search_if.sv
// Candidate/result bus of the SAD search engine. The master is the search-window fetch side.
// The slave is the engine.
interface sad_search_if #(
    parameter int PIX_W = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int IDX_W = 8
);
    localparam int N     = ROWS * COLS;
    localparam int SAD_W = PIX_W + $clog2(N);

    logic                 cur_load;
    logic [N*PIX_W-1:0]   cur_blk;
    logic                 in_valid;
    logic                 in_first;
    logic                 in_last;
    logic [IDX_W-1:0]     in_idx;
    logic [N*PIX_W-1:0]   cand_blk;
    logic                 sad_valid;
    logic [SAD_W-1:0]     sad_out;
    logic [IDX_W-1:0]     sad_idx;
    logic                 best_valid;
    logic [SAD_W-1:0]     best_sad;
    logic [IDX_W-1:0]     best_idx;

    modport master (
        output cur_load, cur_blk, in_valid, in_first, in_last, in_idx, cand_blk,
        input  sad_valid, sad_out, sad_idx, best_valid, best_sad, best_idx
    );

    modport slave (
        input  cur_load, cur_blk, in_valid, in_first, in_last, in_idx, cand_blk,
        output sad_valid, sad_out, sad_idx, best_valid, best_sad, best_idx
    );
endinterface

// File: rtl/sad_search_engine.sv
// Fully pipelined sum-of-absolute-differences engine with a min-SAD search tracker.
// One candidate block per cycle. Latency is 1 + clog2(ROWS*COLS) cycles to sad_valid.
module sad_search_engine #(
    parameter int PIX_W = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int IDX_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    sad_search_if.slave   bus
);
    localparam int N     = ROWS * COLS;
    localparam int T     = $clog2(N);
    localparam int SAD_W = PIX_W + T;
    localparam int L     = 1 + T;
    localparam int P     = 1 << T;

    logic [N*PIX_W-1:0] cur_reg;
    logic [L-1:0]       vld_reg;
    logic [L-1:0]       first_reg;
    logic [L-1:0]       last_reg;
    logic [IDX_W-1:0]   idx_reg [L];

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_reg <= '0;
        end else if (bus.cur_load) begin
            cur_reg <= bus.cur_blk;
        end
    end

    // Sideband shifts alongside the datapath; first/last are qualified by valid at entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg   <= '0;
            first_reg <= '0;
            last_reg  <= '0;
            for (int i = 0; i < L; i++) idx_reg[i] <= '0;
        end else begin
            vld_reg[0]   <= bus.in_valid;
            first_reg[0] <= bus.in_valid & bus.in_first;
            last_reg[0]  <= bus.in_valid & bus.in_last;
            idx_reg[0]   <= bus.in_idx;
            for (int i = 1; i < L; i++) begin
                vld_reg[i]   <= vld_reg[i-1];
                first_reg[i] <= first_reg[i-1];
                last_reg[i]  <= last_reg[i-1];
                idx_reg[i]   <= idx_reg[i-1];
            end
        end
    end

    genvar gi, gl;

    // Leaves: registered |cand - cur| per pixel, zero padding up to a power of two.
    for (gi = 0; gi < P; gi++) begin : pix
        logic [PIX_W-1:0] leaf;
        if (gi < N) begin : real_px
            logic [PIX_W-1:0] c_px, r_px, ad_reg;
            assign c_px = bus.cand_blk[gi*PIX_W +: PIX_W];
            assign r_px = cur_reg[gi*PIX_W +: PIX_W];
            always_ff @(posedge clk) begin
                if (rst) ad_reg <= '0;
                else     ad_reg <= (c_px > r_px) ? (c_px - r_px) : (r_px - c_px);
            end
            assign leaf = ad_reg;
        end else begin : pad_px
            assign leaf = '0;
        end
    end

    for (gl = 1; gl <= T; gl++) begin : lvl
        for (gi = 0; gi < (P >> gl); gi++) begin : node
            logic [PIX_W+gl-2:0] a, b;
            logic [PIX_W+gl-1:0] sum_reg;
            if (gl == 1) begin : from_leaf
                assign a = pix[2*gi].leaf;
                assign b = pix[2*gi+1].leaf;
            end else begin : from_tree
                assign a = lvl[gl-1].node[2*gi].sum_reg;
                assign b = lvl[gl-1].node[2*gi+1].sum_reg;
            end
            always_ff @(posedge clk) begin
                if (rst) sum_reg <= '0;
                else     sum_reg <= {1'b0, a} + {1'b0, b};
            end
        end
    end

    logic [SAD_W-1:0] sad_w;
    assign sad_w = lvl[T].node[0].sum_reg;

    assign bus.sad_valid = vld_reg[L-1];
    assign bus.sad_out   = sad_w;
    assign bus.sad_idx   = idx_reg[L-1];

    logic             open_reg;
    logic [SAD_W-1:0] run_min_reg, min_next;
    logic [IDX_W-1:0] run_idx_reg, idx_next;
    logic             best_valid_reg;
    logic [SAD_W-1:0] best_sad_reg;
    logic [IDX_W-1:0] best_idx_reg;

    // Strict less-than keeps the earlier candidate on ties.
    always_comb begin
        min_next = run_min_reg;
        idx_next = run_idx_reg;
        if (first_reg[L-1] || !open_reg || (sad_w < run_min_reg)) begin
            min_next = sad_w;
            idx_next = idx_reg[L-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_reg       <= 1'b0;
            run_min_reg    <= '0;
            run_idx_reg    <= '0;
            best_valid_reg <= 1'b0;
            best_sad_reg   <= '0;
            best_idx_reg   <= '0;
        end else begin
            best_valid_reg <= 1'b0;
            if (vld_reg[L-1]) begin
                run_min_reg <= min_next;
                run_idx_reg <= idx_next;
                open_reg    <= !last_reg[L-1];
                if (last_reg[L-1]) begin
                    best_valid_reg <= 1'b1;
                    best_sad_reg   <= min_next;
                    best_idx_reg   <= idx_next;
                end
            end
        end
    end

    assign bus.best_valid = best_valid_reg;
    assign bus.best_sad   = best_sad_reg;
    assign bus.best_idx   = best_idx_reg;
endmodule

// File: tb/tb_sad_search_engine.sv
// Scoreboard bench for sad_search_engine: a reference model pushes expected SAD and search results.
// A negedge monitor pops them and compares.
module tb_sad_search_engine;
    localparam int PIX_W = 8;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int IDX_W = 8;
    localparam int N     = ROWS * COLS;
    localparam int LAT   = 5;

    typedef logic [N*PIX_W-1:0] blk_t;
    typedef struct {
        int sad;
        int idx;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    sad_search_if #(.PIX_W(PIX_W), .ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W)) bus ();

    sad_search_engine #(.PIX_W(PIX_W), .ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sad_q[$];
    exp_t best_q[$];
    blk_t cur_m = '0;
    bit   open_m = 1'b0;
    int   min_m = 0;
    int   idx_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sad_of(input blk_t a, input blk_t b);
        int s = 0;
        for (int i = 0; i < N; i++) begin
            int x = int'(a[i*PIX_W +: PIX_W]);
            int y = int'(b[i*PIX_W +: PIX_W]);
            s += (x > y) ? (x - y) : (y - x);
        end
        return s;
    endfunction

    function automatic blk_t flat_blk(input logic [7:0] v);
        blk_t b;
        for (int i = 0; i < N; i++) b[i*PIX_W +: PIX_W] = v;
        return b;
    endfunction

    function automatic blk_t offset_blk(input int d);
        blk_t b = flat_blk(8'h80);
        b[PIX_W-1:0] = 8'(8'h80 + d);
        return b;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < N*PIX_W/32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic beat(input bit v, input bit f, input bit l, input int idx, input blk_t cand,
                        input bit ld = 1'b0, input blk_t nc = '0);
        int   s;
        exp_t e;
        bus.in_valid = v;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_idx   = idx[IDX_W-1:0];
        bus.cand_blk = cand;
        bus.cur_load = ld;
        bus.cur_blk  = nc;
        if (v) begin
            s = sad_of(cur_m, cand);
            e.sad = s; e.idx = idx; e.due = cyc + LAT;
            sad_q.push_back(e);
            if (f || !open_m || s < min_m) begin
                min_m = s;
                idx_m = idx;
            end
            open_m = 1'b1;
            if (l) begin
                e.sad = min_m; e.idx = idx_m; e.due = cyc + LAT + 1;
                best_q.push_back(e);
                open_m = 1'b0;
            end
        end
        if (ld) cur_m = nc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.cur_load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_zero();
        check("rst_sad_valid",  32'(bus.sad_valid),  0);
        check("rst_sad_out",    32'(bus.sad_out),    0);
        check("rst_sad_idx",    32'(bus.sad_idx),    0);
        check("rst_best_valid", 32'(bus.best_valid), 0);
        check("rst_best_sad",   32'(bus.best_sad),   0);
        check("rst_best_idx",   32'(bus.best_idx),   0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.sad_valid === 1'b1) begin
            if (sad_q.size() == 0) begin
                check("sad_valid_spurious", 32'(bus.sad_valid), 0);
            end else begin
                e = sad_q.pop_front();
                $display("sad  idx=%0d sad=%0d cycle=%0d", bus.sad_idx, bus.sad_out, cyc);
                check("sad_out", 32'(bus.sad_out), e.sad);
                check("sad_idx", 32'(bus.sad_idx), e.idx);
                check("sad_latency", cyc, e.due);
            end
        end else if (sad_q.size() > 0 && sad_q[0].due <= cyc) begin
            e = sad_q.pop_front();
            check("sad_valid_missing", 32'(bus.sad_valid), 1);
        end
        if (bus.best_valid === 1'b1) begin
            if (best_q.size() == 0) begin
                check("best_valid_spurious", 32'(bus.best_valid), 0);
            end else begin
                e = best_q.pop_front();
                $display("best idx=%0d sad=%0d cycle=%0d", bus.best_idx, bus.best_sad, cyc);
                check("best_sad", 32'(bus.best_sad), e.sad);
                check("best_idx", 32'(bus.best_idx), e.idx);
                check("best_latency", cyc, e.due);
            end
        end else if (best_q.size() > 0 && best_q[0].due <= cyc) begin
            e = best_q.pop_front();
            check("best_valid_missing", 32'(bus.best_valid), 1);
        end
    end

    initial begin
        blk_t ramp;
        for (int i = 0; i < N; i++) ramp[i*PIX_W +: PIX_W] = 8'(i);
        bus.cur_load = 1'b0; bus.cur_blk  = '0;
        bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.in_idx   = '0;   bus.cand_blk = '0;

        rst = 1'b1;
        idle(3);
        check_zero();
        rst = 1'b0;

        // Identical blocks give zero SAD
        beat(0, 0, 0, 0, '0, 1'b1, ramp);
        beat(1, 0, 0, 5, ramp);

        // Extremes in both directions reach the full-scale SAD
        beat(0, 0, 0, 0, '0, 1'b1, flat_blk(8'h00));
        beat(1, 0, 0, 6, flat_blk(8'hFF));
        beat(0, 0, 0, 0, '0, 1'b1, flat_blk(8'hFF));
        beat(1, 0, 0, 7, flat_blk(8'h00));
        idle(6);

        // Random traffic with bubbles and random search boundaries
        for (int i = 0; i < 12; i++) begin
            beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)), rand_blk());
        end
        idle(8);

        // Four-beat search with a tie
        beat(0, 0, 0, 0, '0, 1'b1, flat_blk(8'h80));
        beat(1, 1, 0, 3, offset_blk(100));
        beat(1, 0, 0, 7, offset_blk(40));
        beat(1, 0, 0, 9, offset_blk(40));
        beat(1, 0, 1, 2, offset_blk(90));

        // Back-to-back searches with no idle cycle
        beat(1, 0, 1, 1, offset_blk(50));
        beat(1, 1, 1, 4, offset_blk(20));
        idle(8);

        // Beat coincident with cur_load still sees the old block
        beat(1, 1, 0, 11, flat_blk(8'h90), 1'b1, flat_blk(8'h10));
        beat(1, 0, 1, 12, flat_blk(8'h90));
        idle(8);

        // Reset in the middle of a search
        beat(1, 1, 0, 20, offset_blk(30));
        beat(1, 0, 0, 21, offset_blk(10));
        rst = 1'b1;
        sad_q.delete();
        best_q.delete();
        open_m = 1'b0;
        cur_m  = '0;
        bus.in_valid = 1'b1; bus.in_idx = 8'd22; bus.cand_blk = offset_blk(5);
        @(posedge clk);
        @(negedge clk);
        check_zero();
        bus.in_last = 1'b1; bus.in_idx = 8'd23;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        idle(8);

        // First beat after reset starts a clean search against the cleared current block
        beat(1, 0, 1, 30, flat_blk(8'h03));
        idle(10);

        check("sad_q_drain",  sad_q.size(),  0);
        check("best_q_drain", best_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
